// File: rtl/cpu_dbg_defs.sv
// Shared encodings for the CPU step controller: FSM state codes and the LCD debug-word selectors.
package cpu_dbg_defs;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_STEP   = 2'd1,
      ST_RUN    = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam logic [1:0] DBG_PC   = 2'd0;
   localparam logic [1:0] DBG_INST = 2'd1;
   localparam logic [1:0] DBG_REG  = 2'd2;
   localparam logic [1:0] DBG_CNT  = 2'd3;

   // Switch field 0 and 1 pick pc/inst, 7 picks the step counter, everything else is a register address.
   function automatic logic [1:0] dbg_decode(input logic [2:0] sel);
      if (sel == 3'd0)      return DBG_PC;
      else if (sel == 3'd1) return DBG_INST;
      else if (sel == 3'd7) return DBG_CNT;
      else                  return DBG_REG;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debounce and a one-cycle rising-edge pulse.
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1, sync2;
   logic          level;
   logic [CW-1:0] cnt;
   logic          accept;

   // The synced input must disagree with the accepted level for DEB_CYCLES cycles in a row.
   assign accept = (sync2 != level) && (cnt == CW'(DEB_CYCLES - 1));

   // NOTE: state is updated with <= so every flop samples pre-edge values; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         rise  <= accept && sync2;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (accept) begin
            cnt   <= '0;
            level <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Pipeline clock-enable sequencer: single-step or free-run advance pulses, step counter,
// debug-word select and the LCD refresh request/acknowledge handshake.
module cpu_step_ctrl
   import cpu_dbg_defs::*;
#(
   parameter int DEB_CYCLES = 16,
   parameter int RUN_DIV    = 8,
   parameter int RST_HOLD   = 4,
   parameter int CNT_W      = 8
) (
   input  logic             CCLK,
   input  logic             RST_N,
   input  logic             BTN_STEP,
   input  logic [3:0]       SW,
   input  logic             halt,
   input  logic             lcd_ack,
   output logic             cpu_en,
   output logic             cpu_rst,
   output logic [CNT_W-1:0] rcnt,
   output logic [1:0]       dbg_sel,
   output logic             lcd_req
);

   localparam int HW = $clog2(RST_HOLD + 1);
   localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

   state_t        state, state_n;
   logic [HW-1:0] hold_cnt;
   logic [DW-1:0] div;
   logic          btn_rise;
   logic          step_req;
   logic          pending;
   logic [1:0]    dbg_new;
   logic          upd_evt;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_step (
      .clk   (CCLK),
      .rst_n (RST_N),
      .btn   (BTN_STEP),
      .rise  (btn_rise)
   );

   assign cpu_rst = (state == ST_INIT);
   assign dbg_new = dbg_decode(SW[3:1]);
   assign upd_evt = cpu_en || (dbg_new != dbg_sel);

   // halt outranks the mode switch and also masks cpu_en combinationally in the same cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      state_n = state;
      cpu_en  = 1'b0;
      case (state)
         ST_INIT: begin
            if (hold_cnt == HW'(RST_HOLD - 1)) state_n = SW[0] ? ST_RUN : ST_STEP;
         end
         ST_STEP: begin
            if (halt) begin
               state_n = ST_HALTED;
            end else begin
               cpu_en = step_req;
               if (SW[0]) state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            if (halt)        state_n = ST_HALTED;
            else if (!SW[0]) state_n = ST_STEP;
            else             cpu_en  = (div == DW'(RUN_DIV - 1));
         end
         ST_HALTED: begin
            if (step_req && !halt) state_n = ST_STEP;
         end
         default: state_n = ST_INIT;
      endcase
   end

   always_ff @(posedge CCLK) begin
      if (!RST_N) begin
         state    <= ST_INIT;
         hold_cnt <= '0;
         div      <= '0;
         step_req <= 1'b0;
         rcnt     <= '0;
         dbg_sel  <= DBG_PC;
      end else begin
         state <= state_n;
         if (state == ST_INIT) hold_cnt <= hold_cnt + 1'b1;
         if (state != ST_RUN || div == DW'(RUN_DIV - 1)) div <= '0;
         else                                            div <= div + 1'b1;
         // Presses are discarded while free-running; otherwise held until a step pulse uses them.
         if (state == ST_RUN)  step_req <= 1'b0;
         else if (btn_rise)    step_req <= 1'b1;
         else if (cpu_en)      step_req <= 1'b0;
         if (cpu_en) rcnt <= rcnt + 1'b1;
         dbg_sel <= dbg_new;
      end
   end

   // Refresh handshake: events during an open request collapse into a single pending re-request.
   always_ff @(posedge CCLK) begin
      if (!RST_N) begin
         lcd_req <= 1'b0;
         pending <= 1'b0;
      end else if (lcd_req) begin
         if (lcd_ack) lcd_req <= 1'b0;
         if (upd_evt) pending <= 1'b1;
      end else if (pending || upd_evt) begin
         lcd_req <= 1'b1;
         pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomised bench for cpu_step_ctrl: expected step pulses are queued by the stimulus, a monitor pops and compares.
module tb_cpu_step_ctrl;

   localparam int RUN_DIV = 8;
   localparam int CNT_W   = 8;

   logic             CCLK     = 1'b0;
   logic             RST_N    = 1'b0;
   logic             BTN_STEP = 1'b0;
   logic [3:0]       SW       = 4'd0;
   logic             halt     = 1'b0;
   logic             lcd_ack  = 1'b0;
   logic             cpu_en, cpu_rst, lcd_req;
   logic [CNT_W-1:0] rcnt;
   logic [1:0]       dbg_sel;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int rcnt_exp;
      bit timed;
      int cyc_exp;
   } pulse_t;

   pulse_t exp_q[$];
   int     model_cnt = 0;
   bit     ack_forced = 1'b0;
   bit     ack_force  = 1'b0;
   logic   prev_req = 1'b0, prev_ack = 1'b0, prev_rstn = 1'b0;

   cpu_step_ctrl #(.DEB_CYCLES(16), .RUN_DIV(RUN_DIV), .RST_HOLD(4), .CNT_W(CNT_W)) dut (
      .CCLK     (CCLK),
      .RST_N    (RST_N),
      .BTN_STEP (BTN_STEP),
      .SW       (SW),
      .halt     (halt),
      .lcd_ack  (lcd_ack),
      .cpu_en   (cpu_en),
      .cpu_rst  (cpu_rst),
      .rcnt     (rcnt),
      .dbg_sel  (dbg_sel),
      .lcd_req  (lcd_req)
   );

   always #5 CCLK = ~CCLK;
   always @(posedge CCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CCLK);
      #1;
   endtask

   // Reference model: a single press yields one pulse at an unspecified latency.
   task automatic expect_step();
      exp_q.push_back('{rcnt_exp: model_cnt % 256, timed: 1'b0, cyc_exp: 0});
      model_cnt++;
   endtask

   // Free-run entered after cycle c0: pulses on every RUN_DIV-th run cycle, timestamped.
   task automatic expect_run(input int c0, input int n);
      for (int j = 1; j <= n; j++) begin
         exp_q.push_back('{rcnt_exp: model_cnt % 256, timed: 1'b1, cyc_exp: c0 + RUN_DIV * j});
         model_cnt++;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge CCLK);
         n++;
      end
      @(negedge CCLK);
      check({name, "_pulses_missing"}, exp_q.size(), 0);
   endtask

   task automatic press();
      int nb = $urandom_range(2, 6);
      for (int i = 0; i < nb; i++) begin
         BTN_STEP = ~BTN_STEP;
         tick($urandom_range(1, 5));
      end
      BTN_STEP = 1'b1;
      tick($urandom_range(25, 40));
      for (int i = 0; i < nb; i++) begin
         BTN_STEP = ~BTN_STEP;
         tick($urandom_range(1, 5));
      end
      BTN_STEP = 1'b0;
      tick($urandom_range(25, 40));
   endtask

   function automatic int dbg_model(input int v);
      if (v == 0) return 0;
      if (v == 1) return 1;
      if (v == 7) return 3;
      return 2;
   endfunction

   // LCD acknowledge: random responder, or a value forced by the stimulus.
   always begin
      @(posedge CCLK);
      #2;
      if (ack_forced) lcd_ack = ack_force;
      else            lcd_ack = lcd_req && ($urandom_range(0, 1) == 0);
   end

   // Monitor: every pulse must match the head of the expected queue; requests only drop after an ack.
   always @(negedge CCLK) begin
      if (RST_N === 1'b1 && cpu_en === 1'b1) begin
         check("pulse_expected", exp_q.size() != 0, 1);
         check("no_en_while_halt", halt, 0);
         if (exp_q.size() != 0) begin
            pulse_t e;
            e = exp_q.pop_front();
            check("rcnt_at_pulse", rcnt, e.rcnt_exp);
            if (e.timed) check("pulse_cycle", cyc, e.cyc_exp);
         end
      end
      if (prev_rstn === 1'b1 && prev_req === 1'b1 && lcd_req === 1'b0)
         check("lcd_drop_after_ack", prev_ack, 1);
      prev_req  = lcd_req;
      prev_ack  = lcd_ack;
      prev_rstn = RST_N;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      int c0, n, k, v;

      // Reset values and init hold
      tick(3);
      @(negedge CCLK);
      check("rst_cpu_en", cpu_en, 0);
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_rcnt", rcnt, 0);
      check("rst_dbg_sel", dbg_sel, 0);
      check("rst_lcd_req", lcd_req, 0);
      @(posedge CCLK);
      #1;
      RST_N = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CCLK);
         if (cpu_rst) n++;
      end
      check("cpu_rst_hold_cycles", n, 4);

      // Bouncy button: toggles every 3 cycles, then held high
      expect_step();
      tick(1);
      for (int i = 0; i < 13; i++) begin
         BTN_STEP = ~BTN_STEP;
         tick(3);
      end
      BTN_STEP = 1'b1;
      tick(20);
      BTN_STEP = 1'b0;
      tick(30);
      drain("debounce", 40);
      check("rcnt_after_debounce", rcnt, model_cnt % 256);

      // Random single steps
      for (int p = 0; p < 3; p++) begin
         expect_step();
         press();
         drain("step_press", 60);
      end

      // Free run for 80 run cycles
      tick(1);
      SW = 4'b0001;
      c0 = cyc;
      expect_run(c0, 80 / RUN_DIV);
      tick(81);
      SW = 4'b0000;
      tick(30);
      drain("run80", 10);
      check("rcnt_after_run", rcnt, model_cnt % 256);

      // Press during free run is discarded
      SW = 4'b0001;
      c0 = cyc;
      expect_run(c0, 199 / RUN_DIV);
      tick(4);
      press();
      tick(c0 + 200 - cyc);
      SW = 4'b0000;
      tick(40);
      drain("run_press", 10);

      // Halt raised exactly on a pulse cycle, then release with a press
      SW = 4'b0001;
      c0 = cyc;
      k = RUN_DIV * $urandom_range(3, 7);
      expect_run(c0, (k - 1) / RUN_DIV);
      tick(k);
      halt = 1'b1;
      tick(12);
      SW = 4'b0000;
      tick(3);
      halt = 1'b0;
      tick(10);
      drain("halt_in_run", 5);
      expect_step();
      press();
      drain("halt_release", 60);
      expect_step();
      press();
      drain("step_after_halt", 60);

      // LCD handshake while halted (no cpu_en traffic)
      halt = 1'b1;
      SW = 4'b0100;
      n = 0;
      k = 0;
      while (k < 3 && n < 200) begin
         @(negedge CCLK);
         k = lcd_req ? 0 : k + 1;
         n++;
      end
      check("lcd_settle", k, 3);
      check("dbg_sel_sw4", dbg_sel, 2);
      tick(1);
      ack_forced = 1'b1;
      ack_force  = 1'b0;
      SW = 4'b0011;
      tick(1);
      @(negedge CCLK);
      check("dbg_sel_sw3", dbg_sel, 1);
      check("lcd_req_on_dbg_change", lcd_req, 1);
      tick(1);
      SW = 4'b1010;
      tick(3);
      SW = 4'b1111;
      tick(3);
      @(negedge CCLK);
      check("lcd_req_held_no_ack", lcd_req, 1);
      check("dbg_sel_sw15", dbg_sel, 3);
      tick(1);
      ack_force = 1'b1;
      tick(1);
      ack_force = 1'b0;
      @(negedge CCLK);
      check("lcd_req_drop_on_ack", lcd_req, 0);
      @(negedge CCLK);
      check("lcd_pending_reraise", lcd_req, 1);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CCLK);
         if (lcd_req) n++;
      end
      check("lcd_reraise_held", n, 3);
      tick(1);
      ack_force = 1'b1;
      tick(1);
      ack_force = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CCLK);
         if (lcd_req) n++;
      end
      check("lcd_single_reraise", n, 0);

      // Ack while idle is ignored
      tick(1);
      ack_force = 1'b1;
      tick(2);
      ack_force = 1'b0;
      tick(1);
      SW = 4'b0010;
      tick(1);
      @(negedge CCLK);
      check("lcd_req_after_idle_ack", lcd_req, 1);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CCLK);
         if (lcd_req) n++;
      end
      check("lcd_req_not_stale_acked", n, 3);

      // Event and ack in the same cycle leave a pending request
      tick(1);
      ack_force = 1'b1;
      SW = 4'b0000;
      tick(1);
      ack_force = 1'b0;
      @(negedge CCLK);
      check("lcd_drop_evt_ack", lcd_req, 0);
      check("dbg_sel_sw0", dbg_sel, 0);
      @(negedge CCLK);
      check("lcd_evt_ack_reraise", lcd_req, 1);
      ack_forced = 1'b0;

      // Random display selects
      for (int i = 0; i < 6; i++) begin
         tick(1);
         v = $urandom_range(0, 7);
         SW = {v[2:0], 1'b0};
         tick(1);
         @(negedge CCLK);
         check("dbg_decode_rand", dbg_sel, dbg_model(v));
      end
      tick(1);
      SW = 4'b0000;
      halt = 1'b0;
      tick(3);
      expect_step();
      press();
      drain("post_lcd_step", 60);

      // Counter wrap over a long free run
      SW = 4'b0001;
      c0 = cyc;
      expect_run(c0, 260);
      tick(260 * RUN_DIV + 1);
      SW = 4'b0000;
      tick(20);
      drain("wrap", 10);
      check("rcnt_after_wrap", rcnt, model_cnt % 256);

      // Reset in the middle of a free run
      SW = 4'b0001;
      c0 = cyc;
      k = RUN_DIV * $urandom_range(2, 5) + 4;
      expect_run(c0, k / RUN_DIV);
      tick(k);
      RST_N = 1'b0;
      SW = 4'b0000;
      tick(1);
      @(negedge CCLK);
      check("midrun_rst_cpu_rst", cpu_rst, 1);
      check("midrun_rst_cpu_en", cpu_en, 0);
      check("midrun_rst_rcnt", rcnt, 0);
      check("midrun_rst_lcd_req", lcd_req, 0);
      drain("midrun", 2);
      model_cnt = 0;
      tick(1);
      RST_N = 1'b1;
      tick(10);
      expect_step();
      press();
      drain("step_after_reset", 60);
      check("rcnt_after_reset_step", rcnt, model_cnt % 256);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
